// File: rtl/gui_palette_panel.sv
// Left-edge palette overlay: a column of colour swatches, a blinking ring on the
// selected swatch and a stroke-width preview bar, with a two-stage pixel pipeline.
module gui_palette_panel #(
    parameter int PANEL_WIDTH  = 100,
    parameter int NUM_SWATCHES = 9,
    parameter int SWATCH_X0    = 30,
    parameter int SWATCH_Y0    = 20,
    parameter int SWATCH_SIZE  = 40,
    parameter int SWATCH_GAP   = 8,
    parameter int RING_PX      = 2,
    parameter int BLINK_LOG2   = 4,
    parameter int DEFAULT_SEL  = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        next_in,
    input  logic        prev_in,
    input  logic [2:0]  stroke_width_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        in_panel_out,
    output logic [3:0]  color_sel_out
);

    localparam int          PITCH     = SWATCH_SIZE + SWATCH_GAP;
    localparam logic [11:0] PANEL_W_L = 12'(PANEL_WIDTH);
    localparam logic [11:0] X_LO      = 12'(SWATCH_X0);
    localparam logic [11:0] X_HI      = 12'(SWATCH_X0 + SWATCH_SIZE);
    localparam logic [11:0] X_RING_LO = 12'(SWATCH_X0 + RING_PX);
    localparam logic [11:0] X_RING_HI = 12'(SWATCH_X0 + SWATCH_SIZE - RING_PX);
    localparam logic [11:0] STROKE_Y  = 12'(SWATCH_Y0 + NUM_SWATCHES * PITCH);
    localparam logic [3:0]  LAST_SEL  = 4'(NUM_SWATCHES - 1);
    localparam logic [3:0]  DEF_SEL   = 4'(DEFAULT_SEL);
    localparam logic [23:0] RGB_BG    = 24'h505050;

    function automatic logic [23:0] palette_rgb(input logic [3:0] idx);
        logic [23:0] rgb;
        case (idx)
            4'd0:    rgb = 24'h000000;
            4'd1:    rgb = 24'hFFFFFF;
            4'd2:    rgb = 24'hFF0000;
            4'd3:    rgb = 24'h00FF00;
            4'd4:    rgb = 24'h0000FF;
            4'd5:    rgb = 24'h00FFFF;
            4'd6:    rgb = 24'hFF00FF;
            4'd7:    rgb = 24'hFFFF00;
            4'd8:    rgb = 24'h808080;
            default: rgb = 24'hFFFFFF;
        endcase
        return rgb;
    endfunction

    logic [3:0]  sel_q, sel_d;
    logic [3:0]  disp_sel_q;
    logic [2:0]  disp_width_q;
    logic [7:0]  frame_cnt_q;
    logic        frame_start;

    always_comb begin
        sel_d = sel_q;
        if (next_in && !prev_in) begin
            sel_d = (sel_q == LAST_SEL) ? 4'd0 : sel_q + 4'd1;
        end else if (prev_in && !next_in) begin
            sel_d = (sel_q == 4'd0) ? LAST_SEL : sel_q - 4'd1;
        end
    end

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // Display state is frozen per frame so a selection change never tears mid-frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_q        <= DEF_SEL;
            disp_sel_q   <= DEF_SEL;
            disp_width_q <= 3'd0;
            frame_cnt_q  <= 8'd0;
        end else begin
            sel_q <= sel_d;
            if (frame_start) begin
                disp_sel_q   <= sel_q;
                disp_width_q <= stroke_width_in;
                frame_cnt_q  <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign color_sel_out = sel_q;

    logic [11:0]             px, py;
    logic                    col_hit, col_edge;
    logic [NUM_SWATCHES-1:0] row_hit, row_edge;
    logic                    in_panel_d, hit_d, ring_d, bar_d;
    logic [3:0]              idx_d;
    logic [11:0]             bar_end;

    assign px       = {1'b0, hcount_in};
    assign py       = {2'b0, vcount_in};
    assign col_hit  = (px >= X_LO) && (px < X_HI);
    assign col_edge = (px < X_RING_LO) || (px >= X_RING_HI);

    // One constant-bound comparator pair per swatch row replaces a divide by PITCH.
    for (genvar gi = 0; gi < NUM_SWATCHES; gi++) begin : g_row
        localparam logic [11:0] TOP     = 12'(SWATCH_Y0 + gi * PITCH);
        localparam logic [11:0] BOT     = 12'(SWATCH_Y0 + gi * PITCH + SWATCH_SIZE);
        localparam logic [11:0] RING_LO = 12'(SWATCH_Y0 + gi * PITCH + RING_PX);
        localparam logic [11:0] RING_HI = 12'(SWATCH_Y0 + gi * PITCH + SWATCH_SIZE - RING_PX);
        assign row_hit[gi]  = col_hit && (py >= TOP) && (py < BOT);
        assign row_edge[gi] = col_edge || (py < RING_LO) || (py >= RING_HI);
    end

    always_comb begin
        hit_d  = 1'b0;
        idx_d  = 4'd0;
        ring_d = 1'b0;
        for (int i = 0; i < NUM_SWATCHES; i++) begin
            if (row_hit[i]) begin
                hit_d  = 1'b1;
                idx_d  = 4'(i);
                ring_d = row_edge[i] && (disp_sel_q == 4'(i));
            end
        end
    end

    assign in_panel_d = px < PANEL_W_L;
    assign bar_end    = STROKE_Y + {8'd0, disp_width_q, 1'b0} + 12'd2;
    assign bar_d      = col_hit && (py >= STROKE_Y) && (py < bar_end);

    // Stage 1: region decode
    logic       vld_p1;
    logic       in_panel_p1, hit_p1, ring_p1, bar_p1, blink_p1;
    logic [3:0] idx_p1, bar_sel_p1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        in_panel_p1 <= in_panel_d;
        hit_p1      <= hit_d;
        idx_p1      <= idx_d;
        ring_p1     <= ring_d;
        bar_p1      <= bar_d;
        bar_sel_p1  <= disp_sel_q;
        blink_p1    <= frame_cnt_q[BLINK_LOG2];
    end

    // Stage 2: colour lookup and priority mux
    logic [23:0] rgb_q, rgb_d;
    logic        in_panel_q;

    always_comb begin
        rgb_d = rgb_q;
        if (vld_p1 && in_panel_p1) begin
            if (ring_p1) begin
                rgb_d = blink_p1 ? 24'h000000 : 24'hFFFFFF;
            end else if (hit_p1) begin
                rgb_d = palette_rgb(idx_p1);
            end else if (bar_p1) begin
                rgb_d = palette_rgb(bar_sel_p1);
            end else begin
                rgb_d = RGB_BG;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rgb_q      <= 24'd0;
            in_panel_q <= 1'b0;
        end else begin
            rgb_q      <= rgb_d;
            in_panel_q <= vld_p1 && in_panel_p1;
        end
    end

    assign red_out      = rgb_q[23:16];
    assign green_out    = rgb_q[15:8];
    assign blue_out     = rgb_q[7:0];
    assign in_panel_out = in_panel_q;

endmodule

// File: tb/tb_gui_palette_panel.sv
// Bench for gui_palette_panel: directed scenarios plus randomized pixels and pulses
// against a frame-level reference model of the palette panel.
module tb_gui_palette_panel;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        next_in, prev_in;
    logic [2:0]  stroke_width_in;
    logic [7:0]  red_out, green_out, blue_out;
    logic        in_panel_out;
    logic [3:0]  color_sel_out;

    gui_palette_panel dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .next_in         (next_in),
        .prev_in         (prev_in),
        .stroke_width_in (stroke_width_in),
        .red_out         (red_out),
        .green_out       (green_out),
        .blue_out        (blue_out),
        .in_panel_out    (in_panel_out),
        .color_sel_out   (color_sel_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [23:0] pal [0:8] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                               24'h00FFFF, 24'hFF00FF, 24'hFFFF00, 24'h808080};

    // Reference state
    int          m_sel, m_dsel, m_dw, m_fc;
    logic [23:0] m_hold;
    bit          pend_inp;
    logic [23:0] pend_rgb;
    int          cur_sw = 0;

    function automatic logic [23:0] rgb_now();
        return {red_out, green_out, blue_out};
    endfunction

    task automatic model_pixel(input int x, input int y, output bit inp, output logic [23:0] rgb);
        int k, off;
        bit col;
        if (x >= 100) begin
            inp = 0;
            rgb = m_hold;
            return;
        end
        inp = 1;
        col = (x >= 30) && (x < 70);
        k   = (y - 20) / 48;
        off = (y - 20) % 48;
        if (col && y >= 20 && k < 9 && off < 40) begin
            if (k == m_dsel && (x - 30 < 2 || x - 30 >= 38 || off < 2 || off >= 38))
                rgb = ((m_fc >> 4) & 1) ? 24'h000000 : 24'hFFFFFF;
            else
                rgb = pal[k];
        end else if (col && y >= 452 && y < 452 + 2 * (m_dw + 1)) begin
            rgb = pal[m_dsel];
        end else begin
            rgb = 24'h505050;
        end
        m_hold = rgb;
    endtask

    task automatic cycle(input int x, input int y, input bit nx, input bit pv);
        bit          c_inp;
        logic [23:0] c_rgb;
        hcount_in       = 11'(x);
        vcount_in       = 10'(y);
        next_in         = nx;
        prev_in         = pv;
        stroke_width_in = 3'(cur_sw);
        model_pixel(x, y, c_inp, c_rgb);
        if (x == 0 && y == 0) begin
            m_dsel = m_sel;
            m_dw   = cur_sw;
            m_fc   = (m_fc + 1) % 256;
        end
        if (nx && !pv) m_sel = (m_sel == 8) ? 0 : m_sel + 1;
        else if (pv && !nx) m_sel = (m_sel == 0) ? 8 : m_sel - 1;
        @(posedge clk_in);
        #1;
        chk("in_panel", 32'(in_panel_out), 32'(pend_inp));
        chk("rgb", 32'(rgb_now()), 32'(pend_rgb));
        chk("color_sel", 32'(color_sel_out), 32'(m_sel));
        pend_inp = c_inp;
        pend_rgb = c_rgb;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
        cycle(x, y, 0, 0);
        cycle(200, 10, 0, 0);
        chk(tag, 32'(rgb_now()), 32'(exp));
    endtask

    task automatic do_reset(input bit check_state);
        rst_n_in        = 1'b0;
        hcount_in       = 11'd200;
        vcount_in       = 10'd10;
        next_in         = 1'b0;
        prev_in         = 1'b0;
        cur_sw          = 0;
        stroke_width_in = 3'd0;
        repeat (3) @(posedge clk_in);
        #1;
        if (check_state) begin
            chk("rst_rgb", 32'(rgb_now()), 32'h0);
            chk("rst_in_panel", 32'(in_panel_out), 32'h0);
            chk("rst_sel", 32'(color_sel_out), 32'd1);
        end
        #1;
        rst_n_in = 1'b1;
        m_sel = 1; m_dsel = 1; m_dw = 0; m_fc = 0; m_hold = 24'h0;
        pend_inp = 0; pend_rgb = 24'h0;
    endtask

    initial begin
        do_reset(1);

        // Steady state after reset
        probe("sw0_fill", 40, 25, 24'h000000);
        probe("sw1_ring", 31, 69, 24'hFFFFFF);
        probe("background", 10, 10, 24'h505050);
        cycle(200, 10, 0, 0);
        cycle(200, 10, 0, 0);
        chk("outside_panel", 32'(in_panel_out), 32'h0);

        // Wrap-around
        repeat (6) cycle(200, 10, 1, 0);
        chk("sel_7", 32'(color_sel_out), 32'd7);
        cycle(200, 10, 1, 0); chk("wrap_8", 32'(color_sel_out), 32'd8);
        cycle(200, 10, 1, 0); chk("wrap_0", 32'(color_sel_out), 32'd0);
        cycle(200, 10, 1, 0); chk("wrap_1", 32'(color_sel_out), 32'd1);
        cycle(200, 10, 0, 1); chk("prev_0", 32'(color_sel_out), 32'd0);
        cycle(200, 10, 0, 1); chk("prev_8", 32'(color_sel_out), 32'd8);

        // Simultaneous pulses
        cycle(200, 10, 1, 1); chk("both_hold", 32'(color_sel_out), 32'd8);

        // Deferred display
        cycle(0, 0, 0, 0);
        probe("ring_sw8", 30, 404, 24'hFFFFFF);
        cycle(200, 10, 1, 0);
        probe("ring_stays", 30, 404, 24'hFFFFFF);
        probe("sw0_not_yet", 30, 20, 24'h000000);
        cycle(0, 0, 0, 0);
        probe("ring_moved", 30, 20, 24'hFFFFFF);
        probe("sw8_fill", 30, 404, 24'h808080);

        // Blink
        do_reset(0);
        repeat (15) begin cycle(0, 0, 0, 0); cycle(200, 10, 0, 0); end
        probe("blink_f15", 31, 69, 24'hFFFFFF);
        cycle(0, 0, 0, 0);
        probe("blink_f16", 31, 69, 24'h000000);
        repeat (16) begin cycle(0, 0, 0, 0); cycle(200, 10, 0, 0); end
        probe("blink_f32", 31, 69, 24'hFFFFFF);

        // Stroke bar
        do_reset(0);
        cycle(0, 0, 0, 0);
        probe("bar_w0_in", 40, 453, 24'hFFFFFF);
        probe("bar_w0_out", 40, 454, 24'h505050);
        cur_sw = 3;
        probe("bar_mid_frame", 40, 455, 24'h505050);
        cycle(0, 0, 0, 0);
        probe("bar_w3_in", 40, 459, 24'hFFFFFF);
        probe("bar_w3_out", 40, 460, 24'h505050);

        // Mid-line asynchronous reset
        cycle(200, 10, 1, 0);
        cycle(45, 100, 0, 0);
        cycle(50, 300, 0, 0);
        chk("pre_reset_panel", 32'(in_panel_out), 32'h1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_rgb", 32'(rgb_now()), 32'h0);
        chk("async_in_panel", 32'(in_panel_out), 32'h0);
        chk("async_sel", 32'(color_sel_out), 32'd1);
        do_reset(0);

        // Randomized pixels, pulses and stroke widths
        for (int n = 0; n < 4000; n++) begin
            int x, y;
            bit nx, pv;
            x = $urandom_range(0, 130);
            y = $urandom_range(0, 520);
            if ($urandom_range(0, 39) == 0) begin x = 0; y = 0; end
            nx = ($urandom_range(0, 7) == 0);
            pv = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) cur_sw = $urandom_range(0, 7);
            cycle(x, y, nx, pv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
